// File: rtl/gpio_cfg_pkg.sv
// Shared configuration layout for the gpiov2 pad controller chain.
package gpio_cfg_pkg;

  localparam int CFG_W = 13;

  localparam int CFG_MGMT_ENA    = 0;
  localparam int CFG_OE_OVR      = 1;
  localparam int CFG_HLD_OVR     = 2;
  localparam int CFG_INP_DIS     = 3;
  localparam int CFG_IB_MODE_SEL = 4;
  localparam int CFG_ANALOG_EN   = 5;
  localparam int CFG_ANALOG_SEL  = 6;
  localparam int CFG_ANALOG_POL  = 7;
  localparam int CFG_SLOW        = 8;
  localparam int CFG_VTRIP_SEL   = 9;
  localparam int CFG_DM_LSB      = 10;
  localparam int CFG_DM_MSB      = 12;

  // Management-owned, output disabled, DM=3'b110.
  localparam logic [CFG_W-1:0] CFG_INIT_DEFAULT = 13'h1803;

  // Field order mirrors the bit indices above (first member is the MSB).
  typedef struct packed {
    logic [2:0] dm;
    logic       vtrip_sel;
    logic       slow;
    logic       analog_pol;
    logic       analog_sel;
    logic       analog_en;
    logic       ib_mode_sel;
    logic       inp_dis;
    logic       hld_ovr;
    logic       oe_ovr;
    logic       mgmt_ena;
  } gpio_cfg_t;

endpackage

// File: rtl/gpio_pad_ctrl_chain_in_filter.sv
// Pad input conditioning: 2-flop synchroniser, debounce filter, edge pulses.
module gpio_in_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt,
  output logic rise,
  output logic fall
);

  // DEB_CYCLES=0 still needs one mismatching cycle before filt follows.
  localparam int DEB_N = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
  localparam int CNT_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_N - 1);

  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;

  // cnt is cleared on reaching CNT_MAX, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0   <= din;
      s1   <= s0;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s1 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filt <= s1;
        cnt  <= '0;
        rise <= s1;
        fall <= ~s1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_pad_ctrl_chain.sv
// Core-side gpiov2 pad controller: serial config chain, output mux, input filter.
module gpio_pad_ctrl_chain
  import gpio_cfg_pkg::*;
#(
  parameter logic [CFG_W-1:0] CFG_INIT   = CFG_INIT_DEFAULT,
  parameter int               DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_shift,
  input  logic       serial_load,
  input  logic       serial_data_in,
  output logic       serial_data_out,
  input  logic       mgmt_out,
  input  logic       mgmt_oe_n,
  input  logic       user_out,
  input  logic       user_oe_n,
  input  logic       pad_in,
  output logic       mgmt_in,
  output logic       user_in,
  output logic       in_rise,
  output logic       in_fall,
  output logic       pad_out,
  output logic       pad_oe_n,
  output logic [2:0] pad_dm,
  output logic       pad_inp_dis,
  output logic       pad_ib_mode_sel,
  output logic       pad_slow,
  output logic       pad_vtrip_sel,
  output logic       pad_hld_ovr,
  output logic       pad_analog_en,
  output logic       pad_analog_sel,
  output logic       pad_analog_pol
);

  logic [CFG_W-1:0] sr;
  gpio_cfg_t        cfg;
  logic             filt;

  // Load samples the pre-shift sr when shift and load coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr              <= '0;
      serial_data_out <= 1'b0;
      cfg             <= gpio_cfg_t'(CFG_INIT);
    end else begin
      serial_data_out <= sr[CFG_W-1];
      if (serial_load)  cfg <= gpio_cfg_t'(sr);
      if (serial_shift) sr  <= {sr[CFG_W-2:0], serial_data_in};
    end
  end

  assign pad_dm          = cfg.dm;
  assign pad_inp_dis     = cfg.inp_dis;
  assign pad_ib_mode_sel = cfg.ib_mode_sel;
  assign pad_slow        = cfg.slow;
  assign pad_vtrip_sel   = cfg.vtrip_sel;
  assign pad_hld_ovr     = cfg.hld_ovr;
  assign pad_analog_en   = cfg.analog_en;
  assign pad_analog_sel  = cfg.analog_sel;
  assign pad_analog_pol  = cfg.analog_pol;

  assign pad_out  = cfg.mgmt_ena ? mgmt_out : user_out;
  assign pad_oe_n = cfg.oe_ovr | (cfg.mgmt_ena ? mgmt_oe_n : user_oe_n);

  gpio_in_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_in_filter (
    .clk  (clk),
    .reset(reset),
    .din  (pad_in & ~cfg.inp_dis),
    .filt (filt),
    .rise (in_rise),
    .fall (in_fall)
  );

  // Ownership only gates the filtered value; the filter itself is shared.
  assign mgmt_in = cfg.mgmt_ena & filt;
  assign user_in = ~cfg.mgmt_ena & filt;

endmodule
